// File: rtl/operand_fetch_pkg.sv
// Shared defaults for the operand fetch stage and its scoreboard.
// Optional feature macro: OPERAND_FETCH_BYPASS_EN (writeback-to-operand bypass).
package operand_fetch_pkg;

    localparam int DEF_DATAPATH_WIDTH = 64;
    localparam int DEF_REGFILE_ADDR   = 3;
    localparam int DEF_CTRL_WIDTH     = 16;
    localparam int NUM_REGS           = 2 ** DEF_REGFILE_ADDR;

endpackage : operand_fetch_pkg

// File: rtl/operand_fetch_scoreboard.sv
// Per-register pending bits: set on issue of a writing instruction, cleared by
// writeback or by flushing the held instruction. A set beats a clear on the same bit.
module operand_fetch_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int REGFILE_ADDR = DEF_REGFILE_ADDR
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         set_en_i,
    input  logic [REGFILE_ADDR-1:0]      set_addr_i,
    input  logic                         clr_en_i,
    input  logic [REGFILE_ADDR-1:0]      clr_addr_i,
    input  logic                         flush_en_i,
    input  logic [REGFILE_ADDR-1:0]      flush_addr_i,
    output logic [2**REGFILE_ADDR-1:0]   pending_o
);

    localparam int NREGS = 2 ** REGFILE_ADDR;

    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] pending_q;

    // Next-state of every pending bit, set has priority over both clears.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NREGS; i++) begin
            if (set_en_i && (set_addr_i == REGFILE_ADDR'(i))) begin
                pending_d[i] = 1'b1;
            end else if ((clr_en_i && (clr_addr_i == REGFILE_ADDR'(i))) ||
                         (flush_en_i && (flush_addr_i == REGFILE_ADDR'(i)))) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule : operand_fetch_scoreboard

// File: rtl/operand_fetch.sv
// Operand fetch stage: hazard check against a scoreboard, operand selection, one output register.
// Optional feature macro: OPERAND_FETCH_BYPASS_EN (writeback data forwarded to operands).
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATAPATH_WIDTH = DEF_DATAPATH_WIDTH,
    parameter int REGFILE_ADDR   = DEF_REGFILE_ADDR,
    parameter int CTRL_WIDTH     = DEF_CTRL_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REGFILE_ADDR-1:0]   in_rs0,
    input  logic [REGFILE_ADDR-1:0]   in_rs1,
    input  logic [REGFILE_ADDR-1:0]   in_rd,
    input  logic                      in_rs0_en,
    input  logic                      in_rs1_en,
    input  logic                      in_wb,
    input  logic [CTRL_WIDTH-1:0]     in_ctrl,
    output logic [REGFILE_ADDR-1:0]   rf_r0addr,
    output logic [REGFILE_ADDR-1:0]   rf_r1addr,
    input  logic [DATAPATH_WIDTH-1:0] rf_r0data,
    input  logic [DATAPATH_WIDTH-1:0] rf_r1data,
    input  logic                      wb_wena,
    input  logic [REGFILE_ADDR-1:0]   wb_waddr,
    input  logic [DATAPATH_WIDTH-1:0] wb_wdata,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATAPATH_WIDTH-1:0] out_op0,
    output logic [DATAPATH_WIDTH-1:0] out_op1,
    output logic [REGFILE_ADDR-1:0]   out_rd,
    output logic                      out_wb,
    output logic [CTRL_WIDTH-1:0]     out_ctrl
);

    logic [2**REGFILE_ADDR-1:0] pending_s;
    logic                       byp0_s, byp1_s, hazard_s, accept_s;
    logic [DATAPATH_WIDTH-1:0]  op0_s, op1_s;

    logic                       out_valid_d, out_valid_q;
    logic [DATAPATH_WIDTH-1:0]  out_op0_d, out_op0_q, out_op1_d, out_op1_q;
    logic [REGFILE_ADDR-1:0]    out_rd_d, out_rd_q;
    logic                       out_wb_d, out_wb_q;
    logic [CTRL_WIDTH-1:0]      out_ctrl_d, out_ctrl_q;

    assign rf_r0addr = in_rs0;
    assign rf_r1addr = in_rs1;

`ifdef OPERAND_FETCH_BYPASS_EN
    assign byp0_s = wb_wena && (wb_waddr == in_rs0);
    assign byp1_s = wb_wena && (wb_waddr == in_rs1);
`else
    assign byp0_s = 1'b0;
    assign byp1_s = 1'b0;
`endif

    // A pending source stalls unless its value arrives on the writeback bus now.
    assign hazard_s = (in_rs0_en && pending_s[in_rs0] && !byp0_s) ||
                      (in_rs1_en && pending_s[in_rs1] && !byp1_s) ||
                      (in_wb && pending_s[in_rd] && !(wb_wena && (wb_waddr == in_rd)));
    assign in_ready = !hazard_s && !flush && (!out_valid_q || out_ready);
    assign accept_s = in_valid && in_ready;

    // Operand select: disabled source reads as zero, bypass ahead of register file.
    always_comb begin
        op0_s = '0;
        op1_s = '0;
        if (!in_rs0_en) begin
            op0_s = '0;
        end else if (byp0_s) begin
            op0_s = wb_wdata;
        end else begin
            op0_s = rf_r0data;
        end
        if (!in_rs1_en) begin
            op1_s = '0;
        end else if (byp1_s) begin
            op1_s = wb_wdata;
        end else begin
            op1_s = rf_r1data;
        end
    end

    // Output register next-state: load on accept, drop on flush or transfer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_op0_d   = out_op0_q;
        out_op1_d   = out_op1_q;
        out_rd_d    = out_rd_q;
        out_wb_d    = out_wb_q;
        out_ctrl_d  = out_ctrl_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_op0_d   = op0_s;
            out_op1_d   = op1_s;
            out_rd_d    = in_rd;
            out_wb_d    = in_wb;
            out_ctrl_d  = in_ctrl;
        end else if (flush || out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_op0_q   <= '0;
            out_op1_q   <= '0;
            out_rd_q    <= '0;
            out_wb_q    <= 1'b0;
            out_ctrl_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_op0_q   <= out_op0_d;
            out_op1_q   <= out_op1_d;
            out_rd_q    <= out_rd_d;
            out_wb_q    <= out_wb_d;
            out_ctrl_q  <= out_ctrl_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op0   = out_op0_q;
    assign out_op1   = out_op1_q;
    assign out_rd    = out_rd_q;
    assign out_wb    = out_wb_q;
    assign out_ctrl  = out_ctrl_q;

    operand_fetch_scoreboard #(
        .REGFILE_ADDR (REGFILE_ADDR)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .set_en_i     (accept_s && in_wb),
        .set_addr_i   (in_rd),
        .clr_en_i     (wb_wena),
        .clr_addr_i   (wb_waddr),
        .flush_en_i   (flush && out_valid_q && out_wb_q),
        .flush_addr_i (out_rd_q),
        .pending_o    (pending_s)
    );

endmodule : operand_fetch
